nibble_control_unit: RTL
========================

NIBBLE_CONTROL_UNIT -- requirements
Module: nibble_control_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 run  input  1  high permits the next instruction fetch; low stalls in FETCH.
REQ-005 pc  output  5  instruction-memory address (program counter).
REQ-006 imem_data  input  8  instruction word, combinational from pc in the same cycle; format {op[2:0], i, opnd[3:0]}.
REQ-007 dmem_addr  output  4  data-memory address, equals IR[3:0].
REQ-008 dmem_re  output  1  data-memory read strobe; rdata is valid in the following cycle.
REQ-009 dmem_we  output  1  data-memory write strobe; the datapath writes the accumulator.
REQ-010 acc_we  output  1  accumulator load strobe.
REQ-011 alu_op  output  2  00 pass operand, 01 add-with-carry, 10 NOR, 11 unused.
REQ-012 opnd_sel  output  1  1 selects imm, 0 selects dmem read data.
REQ-013 imm  output  4  equals IR[3:0], zero-extended by the datapath.
REQ-014 alu_cout  input  1  carry-out of the current ALU result.
REQ-015 acc_zero  input  1  high when the accumulator equals 0.
REQ-016 c_flag  output  1  carry flag register, fed to the ALU carry-in.
REQ-017 halted  output  1  high while in state HALT.

Function
REQ-018 Opcode decode SHALL be: 000/i=0 STA; 000/i=1 HALT; 001 LDA; 010 ADC; 011 NOR; 100 SETC; 101 JNZ; 110 JNC; 111 JMP.
REQ-019 For LDA, ADC and NOR, i=1 SHALL select the immediate operand and i=0 SHALL select the memory operand; i SHALL be ignored for JNZ, JNC and JMP.
REQ-020 The FSM SHALL have the states FETCH, READ, EXEC and HALT.
REQ-021 In FETCH with run=1, IR SHALL latch imem_data and the FSM SHALL go to READ for a memory-operand LDA, ADC or NOR, and to EXEC otherwise.
REQ-022 In FETCH with run=0, the FSM SHALL hold: IR unchanged, pc unchanged, all strobes 0.
REQ-023 READ SHALL assert dmem_re=1 for exactly one cycle, then go to EXEC.
REQ-024 EXEC SHALL last one cycle, assert the strobes for the instruction in IR, update pc, and return to FETCH.
REQ-025 Strobes SHALL be 0 in every state other than those stated.
REQ-026 Latency SHALL be 2 cycles per instruction, or 3 cycles for memory-operand LDA, ADC and NOR.
REQ-027 LDA in EXEC SHALL drive acc_we=1 and alu_op=00, with opnd_sel equal to IR[4].
REQ-028 ADC in EXEC SHALL drive acc_we=1 and alu_op=01, with opnd_sel equal to IR[4], and c_flag SHALL load alu_cout.
REQ-029 NOR in EXEC SHALL drive acc_we=1 and alu_op=10, with opnd_sel equal to IR[4]; c_flag SHALL be unchanged.
REQ-030 STA in EXEC SHALL drive dmem_we=1 for one cycle.
REQ-031 SETC in EXEC SHALL load IR[4] into c_flag.
REQ-032 Non-jump instructions SHALL set pc to pc+1 modulo 32 (31 wraps to 0).
REQ-033 JMP SHALL set pc to {0, IR[3:0]}.
REQ-034 JNZ SHALL take the jump when acc_zero=0, and JNC when c_flag=0; otherwise pc SHALL become pc+1.
REQ-035 acc_zero and c_flag SHALL be sampled in the EXEC cycle.
REQ-036 HALT SHALL enter state HALT from EXEC without changing pc.
REQ-037 In HALT: halted=1, all strobes 0, and pc, IR and c_flag frozen; run SHALL be ignored; only reset exits.
REQ-038 A run change outside FETCH SHALL NOT affect the instruction in progress.

Reset
REQ-039 On reset the block SHALL set state=FETCH, pc=0, IR=0, c_flag=0 and halted=0, with all strobes 0 in the following cycle.
REQ-040 Reset SHALL take priority over every other event in any state, including mid-READ or mid-EXEC; a pending dmem_we SHALL be suppressed.

Verification
REQ-041 Immediate load: reset, run=1, imem[0]=0x35 -> cycle 1 FETCH pc=0; cycle 2 acc_we=1, alu_op=00, opnd_sel=1, imm=5; cycle 3 pc=1.
REQ-042 Memory ADC: imem[0]=0x48 with alu_cout=1 -> dmem_re=1 and dmem_addr=8 for one cycle; next cycle acc_we=1, alu_op=01, opnd_sel=0, c_flag=1; then pc=1.
REQ-043 Branches: JNZ 0xA3 with acc_zero=0 -> pc=3, with acc_zero=1 -> pc+1; JNC 0xC5 after SETC 0x90 (c_flag=1) -> pc+1; JMP 0xED -> pc=13.
REQ-044 Halt: imem[2]=0x10 -> halted=1 and pc=2 held for 20 cycles with run toggling and no strobes; reset -> pc=0, halted=0.
REQ-045 Wrap and stall: all imem=0x80 -> pc steps 0..31 then 0, c_flag=0; run=0 for 5 cycles -> pc frozen and strobes 0.
REQ-046 Reset mid-EXEC of STA 0x08 -> dmem_we stays 0, and the next cycle is FETCH with pc=0.

Source files
------------

// File: rtl/nibble_control_unit.sv
// ============================================================================
// Module  : nibble_control_unit
// Purpose : FETCH/READ/EXEC/HALT sequencer for a 4-bit accumulator CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [4:0] pc,
  input  logic [7:0] imem_data,
  output logic [3:0] dmem_addr,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       acc_we,
  output logic [1:0] alu_op,
  output logic       opnd_sel,
  output logic [3:0] imm,
  input  logic       alu_cout,
  input  logic       acc_zero,
  output logic       c_flag,
  output logic       halted
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [2:0] OP_SYS  = 3'd0;  // i=0 STA, i=1 HALT
  localparam logic [2:0] OP_LDA  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_SETC = 3'd4;
  localparam logic [2:0] OP_JNZ  = 3'd5;
  localparam logic [2:0] OP_JNC  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADC  = 2'b01;
  localparam logic [1:0] ALU_NOR  = 2'b10;

  logic [1:0] state;
  logic [7:0] ir;

  logic [2:0] ir_op;
  logic       ir_imm;
  logic [2:0] fetch_op;
  logic       fetch_imm;
  logic       fetch_needs_read;
  logic       ir_is_alu;
  logic       ir_is_halt;
  logic       take_jump;
  logic [4:0] pc_inc;
  logic [4:0] pc_target;

  assign ir_op     = ir[7:5];
  assign ir_imm    = ir[4];
  assign fetch_op  = imem_data[7:5];
  assign fetch_imm = imem_data[4];

  // Only memory-operand ALU instructions need the extra READ cycle.
  assign fetch_needs_read = ((fetch_op == OP_LDA) || (fetch_op == OP_ADC) ||
                             (fetch_op == OP_NOR)) && !fetch_imm;

  assign ir_is_alu  = (ir_op == OP_LDA) || (ir_op == OP_ADC) || (ir_op == OP_NOR);
  assign ir_is_halt = (ir_op == OP_SYS) && ir_imm;

  assign pc_inc    = pc + 5'd1;
  assign pc_target = {1'b0, ir[3:0]};

  always_comb begin
    take_jump = 1'b0;
    case (ir_op)
      OP_JMP:  take_jump = 1'b1;
      OP_JNZ:  take_jump = !acc_zero;
      OP_JNC:  take_jump = !c_flag;
      default: take_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc     <= 5'd0;
      ir     <= 8'd0;
      c_flag <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run) begin
            ir    <= imem_data;
            state <= fetch_needs_read ? ST_READ : ST_EXEC;
          end
        end
        ST_READ: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ir_is_halt) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
            pc    <= take_jump ? pc_target : pc_inc;
          end
          if (ir_op == OP_ADC) begin
            c_flag <= alu_cout;
          end else if (ir_op == OP_SETC) begin
            c_flag <= ir_imm;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  assign dmem_addr = ir[3:0];
  assign imm       = ir[3:0];
  assign halted    = (state == ST_HALT);

  // Strobes are masked by reset so an instruction caught mid-cycle never commits.
  always_comb begin
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    acc_we   = 1'b0;
    alu_op   = ALU_PASS;
    opnd_sel = 1'b0;
    if (!reset) begin
      if (state == ST_READ) begin
        dmem_re = 1'b1;
      end
      if (state == ST_EXEC) begin
        dmem_we = (ir_op == OP_SYS) && !ir_imm;
        if (ir_is_alu) begin
          acc_we   = 1'b1;
          opnd_sel = ir_imm;
          case (ir_op)
            OP_ADC:  alu_op = ALU_ADC;
            OP_NOR:  alu_op = ALU_NOR;
            default: alu_op = ALU_PASS;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire
